// File: rtl/div_pkg.sv
// Shared types and helpers for the fixed-point divider sequencer.
package div_pkg;

    localparam int unsigned DivN   = 33;
    localparam int unsigned DivQ   = 33;
    localparam int unsigned SmMaxW = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StOut
    } div_state_e;

    function automatic int unsigned timeout_cycles(input int unsigned n, input int unsigned q);
        return 2 * (n + q) + 8;
    endfunction

    // x is a sign-extended two's-complement value; result is {sign, mag[w-2:0]} in the low w
    // bits, with the most negative value saturated to the largest representable magnitude.
    function automatic logic [SmMaxW-1:0] to_sign_mag(input logic [SmMaxW-1:0] x,
                                                      input int unsigned w);
        logic              sign;
        logic [SmMaxW-1:0] mag;
        logic [SmMaxW-1:0] lim;
        sign = x[SmMaxW-1];
        mag  = sign ? (~x + 64'd1) : x;
        lim  = (64'd1 << (w - 1)) - 64'd1;
        if (mag > lim) begin
            mag = lim;
        end
        return mag | (64'(sign) << (w - 1));
    endfunction

endpackage

// File: rtl/sm_to_twos.sv
// Sign-magnitude to two's-complement converter; a negative zero maps to zero.
module sm_to_twos #(
    parameter int unsigned W = 66
) (
    input  logic         sign,
    input  logic [W-2:0] mag,
    output logic [W-1:0] value
);

    logic [W-1:0] ext;

    assign ext   = {1'b0, mag};
    assign value = sign ? (W'(0) - ext) : ext;

endmodule

// File: rtl/fix_div_ctrl.sv
// Sequencer around the sign-magnitude fixed-point divider: operand conversion, launch,
// completion tracking, divide-by-zero saturation and timeout.
module fix_div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned N       = DivN,
    parameter int unsigned Q       = DivQ,
    parameter int unsigned TIMEOUT = timeout_cycles(N, Q)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [N-1:0]   s_dividend,
    input  logic [N-1:0]   s_divisor,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N+Q-1:0] m_quotient,
    output logic           m_div0,
    output logic           m_timeout,
    output logic [N-1:0]   div_dividend,
    output logic [N-1:0]   div_divisor,
    output logic           div_start,
    input  logic [N-1:0]   div_quotient_int,
    input  logic [Q-1:0]   div_quotient_frac,
    input  logic           div_complete
);

    localparam int unsigned W    = N + Q;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    quo_q, quo_d;
    logic            div0_q, div0_d;
    logic            tmo_q, tmo_d;

    logic            tmo_hit;
    logic            cvt_sign;
    logic [W-2:0]    cvt_mag;
    logic [W-1:0]    cvt_value;

    assign tmo_hit = (cnt_q == CntW'(TIMEOUT - 1));

    // One converter serves both the divide-by-zero saturation (IDLE) and the divider result.
    assign cvt_sign = (state_q == StIdle) ? s_dividend[N-1] : div_quotient_int[N-1];
    assign cvt_mag  = (state_q == StIdle)
                    ? ((s_dividend == '0) ? '0 : {(W-1){1'b1}})
                    : {div_quotient_int[N-2:0], div_quotient_frac};

    sm_to_twos #(
        .W(W)
    ) u_sm_to_twos (
        .sign (cvt_sign),
        .mag  (cvt_mag),
        .value(cvt_value)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        div0_d    = div0_q;
        tmo_d     = tmo_q;
        s_ready   = 1'b0;
        div_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    dvd_d  = N'(to_sign_mag(SmMaxW'(signed'(s_dividend)), N));
                    dvs_d  = N'(to_sign_mag(SmMaxW'(signed'(s_divisor)), N));
                    tmo_d  = 1'b0;
                    if (s_divisor == '0) begin
                        quo_d   = cvt_value;
                        div0_d  = 1'b1;
                        state_d = StOut;
                    end else begin
                        div0_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = StLaunch;
                    end
                end
            end

            StLaunch, StWaitBusy, StWaitDone: begin
                cnt_d = cnt_q + CntW'(1);
                if (tmo_hit) begin
                    // Timeout wins over a done seen in the same cycle.
                    quo_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = StOut;
                end else if (state_q == StLaunch) begin
                    if (div_complete) begin
                        div_start = 1'b1;
                        state_d   = StWaitBusy;
                    end
                end else if (state_q == StWaitBusy) begin
                    if (!div_complete) begin
                        state_d = StWaitDone;
                    end
                end else if (div_complete) begin
                    quo_d   = cvt_value;
                    state_d = StOut;
                end
            end

            StOut: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            div0_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            div0_q  <= div0_d;
            tmo_q   <= tmo_d;
        end
    end

    assign m_valid      = (state_q == StOut);
    assign m_quotient   = quo_q;
    assign m_div0       = div0_q;
    assign m_timeout    = tmo_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule
